// File: rtl/issue_scoreboard_pkg.sv
// rtl/issue_scoreboard_pkg.sv - shared pipeline constants, FSM state type and jump encoding
package issue_scoreboard_pkg;

  localparam int NUM_REGS = 64;
  localparam int IDX_W    = 6;

  typedef enum logic {
    RUN,
    FLUSH
  } sb_state_e;

  // Execution-stage pcjumpenable encoding; any non-zero code redirects the PC.
  localparam logic [1:0] PCJ_NONE     = 2'd0;
  localparam logic [1:0] PCJ_DIRECT   = 2'd1;
  localparam logic [1:0] PCJ_INDIRECT = 2'd2;
  localparam logic [1:0] PCJ_RETURN   = 2'd3;

  function automatic logic jump_from_pcj(input logic [1:0] pcj);
    return pcj != PCJ_NONE;
  endfunction

endpackage

// File: rtl/issue_scoreboard_if.sv
// rtl/issue_scoreboard_if.sv - decoder/execution bundle seen by the issue scoreboard
interface issue_scoreboard_if #(
  parameter int IDX_W = issue_scoreboard_pkg::IDX_W,
  parameter int CNT_W = 16
);

  logic             issue_valid;
  logic [IDX_W-1:0] issue_src1;
  logic [IDX_W-1:0] issue_src2;
  logic [IDX_W-1:0] issue_src3;
  logic [2:0]       issue_src_en;
  logic [IDX_W-1:0] issue_dst1;
  logic [IDX_W-1:0] issue_dst2;
  logic [1:0]       issue_dst_en;
  logic             issue_ready;
  logic             exec_valid;
  logic             squash;
  logic             wb_wr1_enable;
  logic             wb_wr2_enable;
  logic [IDX_W-1:0] wb_wr1;
  logic [IDX_W-1:0] wb_wr2;
  logic             jump_taken;
  logic [CNT_W-1:0] stall_count;
  logic             busy_any;

  modport slave (
    input  issue_valid, issue_src1, issue_src2, issue_src3, issue_src_en,
    input  issue_dst1, issue_dst2, issue_dst_en,
    input  wb_wr1_enable, wb_wr2_enable, wb_wr1, wb_wr2, jump_taken,
    output issue_ready, exec_valid, squash, stall_count, busy_any
  );

  modport master (
    output issue_valid, issue_src1, issue_src2, issue_src3, issue_src_en,
    output issue_dst1, issue_dst2, issue_dst_en,
    output wb_wr1_enable, wb_wr2_enable, wb_wr1, wb_wr2, jump_taken,
    input  issue_ready, exec_valid, squash, stall_count, busy_any
  );

endinterface

// File: rtl/issue_scoreboard_busy_table.sv
// rtl/issue_scoreboard_busy_table.sv - per-register pending-write bits
// One set port (two destinations), two clear ports, three read and two write-check ports.
module busy_table #(
  parameter int NUM_REGS = 64,
  parameter int IDX_W    = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            set_en_i,
  input  logic [1:0][IDX_W-1:0] set_idx_i,
  input  logic [1:0]            clr_en_i,
  input  logic [1:0][IDX_W-1:0] clr_idx_i,
  input  logic [2:0][IDX_W-1:0] rd_idx_i,
  output logic [2:0]            rd_busy_o,
  input  logic [1:0][IDX_W-1:0] chk_idx_i,
  output logic [1:0]            chk_busy_o,
  output logic                  busy_any_o
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Sets are applied after clears: a newly issued writer is younger than any completion.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < 2; i++) begin
      if (clr_en_i[i]) busy_d[clr_idx_i[i]] = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      if (set_en_i[i]) busy_d[set_idx_i[i]] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rd_busy_o  = '0;
    chk_busy_o = '0;
    for (int i = 0; i < 3; i++) rd_busy_o[i]  = busy_q[rd_idx_i[i]];
    for (int i = 0; i < 2; i++) chk_busy_o[i] = busy_q[chk_idx_i[i]];
  end

  assign busy_any_o = |busy_q;

endmodule

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - RAW/WAW issue hold, post-jump squash window and stall counter
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int NUM_REGS     = issue_scoreboard_pkg::NUM_REGS,
  parameter int IDX_W        = issue_scoreboard_pkg::IDX_W,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                clock,
  input  logic                reset,
  issue_scoreboard_if.slave   bus
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  sb_state_e        state_q;
  logic [2:0]       flush_cnt_q;
  logic [CNT_W-1:0] stall_q;

  logic [2:0] rd_busy;
  logic [1:0] chk_busy;
  logic       hazard;
  logic       in_run;
  logic       stall_inc;

  busy_table #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_busy_table (
    .clock      (clock),
    .reset      (reset),
    .set_en_i   ({2{bus.exec_valid}} & bus.issue_dst_en),
    .set_idx_i  ({bus.issue_dst2, bus.issue_dst1}),
    .clr_en_i   ({bus.wb_wr2_enable, bus.wb_wr1_enable}),
    .clr_idx_i  ({bus.wb_wr2, bus.wb_wr1}),
    .rd_idx_i   ({bus.issue_src3, bus.issue_src2, bus.issue_src1}),
    .rd_busy_o  (rd_busy),
    .chk_idx_i  ({bus.issue_dst2, bus.issue_dst1}),
    .chk_busy_o (chk_busy),
    .busy_any_o (bus.busy_any)
  );

  assign hazard    = |(rd_busy & bus.issue_src_en) | |(chk_busy & bus.issue_dst_en);
  assign in_run    = (state_q == RUN);
  assign stall_inc = in_run & bus.issue_valid & hazard & ~bus.jump_taken;

  assign bus.issue_ready = in_run & ~bus.jump_taken & ~hazard;
  assign bus.exec_valid  = bus.issue_valid & bus.issue_ready;
  assign bus.squash      = ~in_run | bus.jump_taken;
  assign bus.stall_count = stall_q;

  // The jump cycle itself is the first squashed cycle, so FLUSH lasts FLUSH_CYCLES-1 cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
      stall_q     <= '0;
    end else begin
      if (stall_inc && !(&stall_q)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      unique case (state_q)
        RUN: begin
          if (bus.jump_taken && FLUSH_CYCLES > 1) begin
            state_q     <= FLUSH;
            flush_cnt_q <= FLUSH_LOAD;
          end
        end
        FLUSH: begin
          if (bus.jump_taken) begin
            flush_cnt_q <= FLUSH_LOAD;
          end else if (flush_cnt_q <= 3'd1) begin
            flush_cnt_q <= '0;
            state_q     <= RUN;
          end else begin
            flush_cnt_q <= flush_cnt_q - 3'd1;
          end
        end
        default: begin
          state_q     <= RUN;
          flush_cnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb/tb_issue_scoreboard.sv - directed and random checks of issue_scoreboard against a behavioural model
module tb_issue_scoreboard;

  localparam int NR = 64;
  localparam int IW = 6;
  localparam int FC = 2;
  localparam int CW = 4;
  localparam int STALL_MAX = (1 << CW) - 1;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  issue_scoreboard_if #(.IDX_W(IW), .CNT_W(CW)) bus ();

  issue_scoreboard #(
    .NUM_REGS     (NR),
    .IDX_W        (IW),
    .FLUSH_CYCLES (FC),
    .CNT_W        (CW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  bit m_busy [NR];
  int m_squash_left;
  int m_stall;
  int checks   = 0;
  int failures = 0;
  bit last_squash;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic bit model_hazard();
    bit h = 0;
    if (bus.issue_src_en[0] && m_busy[bus.issue_src1]) h = 1;
    if (bus.issue_src_en[1] && m_busy[bus.issue_src2]) h = 1;
    if (bus.issue_src_en[2] && m_busy[bus.issue_src3]) h = 1;
    if (bus.issue_dst_en[0] && m_busy[bus.issue_dst1]) h = 1;
    if (bus.issue_dst_en[1] && m_busy[bus.issue_dst2]) h = 1;
    return h;
  endfunction

  function automatic bit model_any();
    foreach (m_busy[i]) if (m_busy[i]) return 1;
    return 0;
  endfunction

  task automatic idle();
    bus.issue_valid   = 0;
    bus.issue_src1    = '0;
    bus.issue_src2    = '0;
    bus.issue_src3    = '0;
    bus.issue_src_en  = '0;
    bus.issue_dst1    = '0;
    bus.issue_dst2    = '0;
    bus.issue_dst_en  = '0;
    bus.wb_wr1_enable = 0;
    bus.wb_wr2_enable = 0;
    bus.wb_wr1        = '0;
    bus.wb_wr2        = '0;
    bus.jump_taken    = 0;
  endtask

  // Inputs are already driven; compare outputs mid-cycle, then advance the model across the edge.
  task automatic step();
    bit hz, sq, rdy, acc;
    #2;
    hz  = model_hazard();
    sq  = bus.jump_taken || (m_squash_left > 0);
    rdy = !sq && !hz;
    acc = rdy && bus.issue_valid;
    last_squash = bus.squash;
    check("issue_ready", bus.issue_ready, rdy);
    check("exec_valid",  bus.exec_valid,  acc);
    check("squash",      bus.squash,      sq);
    check("busy_any",    bus.busy_any,    model_any());
    check("stall_count", bus.stall_count, m_stall);
    @(posedge clock);
    if (reset) begin
      foreach (m_busy[i]) m_busy[i] = 0;
      m_squash_left = 0;
      m_stall = 0;
    end else begin
      if (m_squash_left == 0 && bus.issue_valid && hz && !bus.jump_taken && m_stall < STALL_MAX)
        m_stall++;
      if (bus.wb_wr1_enable) m_busy[bus.wb_wr1] = 0;
      if (bus.wb_wr2_enable) m_busy[bus.wb_wr2] = 0;
      if (acc && bus.issue_dst_en[0]) m_busy[bus.issue_dst1] = 1;
      if (acc && bus.issue_dst_en[1]) m_busy[bus.issue_dst2] = 1;
      if (bus.jump_taken) m_squash_left = FC - 1;
      else if (m_squash_left > 0) m_squash_left--;
    end
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic clear_all();
    idle();
    for (int r = 0; r < NR; r += 2) begin
      bus.wb_wr1_enable = 1; bus.wb_wr1 = IW'(r);
      bus.wb_wr2_enable = 1; bus.wb_wr2 = IW'(r + 1);
      if (model_any()) step();
    end
    idle();
    step();
  endtask

  initial begin
    int sq;
    m_squash_left = 0;
    m_stall = 0;
    idle();
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
    check("rst_busy_any", bus.busy_any, 0);
    check("rst_squash",   bus.squash,   0);
    check("rst_stall",    bus.stall_count, 0);

    // RAW on r5
    bus.issue_valid = 1; bus.issue_dst1 = 5; bus.issue_dst_en = 2'b01;
    step();
    check("raw_busy_any", bus.busy_any, 1);
    idle();
    bus.issue_valid = 1; bus.issue_src1 = 5; bus.issue_src_en = 3'b001;
    repeat (3) step();
    bus.wb_wr1_enable = 1; bus.wb_wr1 = 5;
    step();
    bus.wb_wr1_enable = 0;
    #2 check("raw_resume", bus.issue_ready, 1);
    step();
    check("raw_stall_cnt", bus.stall_count, 4);

    // WAW on r7, independent r3->r4 passes
    idle();
    bus.issue_valid = 1; bus.issue_dst1 = 7; bus.issue_dst_en = 2'b01;
    step();
    bus.issue_dst1 = 0; bus.issue_dst2 = 7; bus.issue_dst_en = 2'b10;
    #2 check("waw_stall", bus.issue_ready, 0);
    step();
    idle();
    bus.issue_valid = 1; bus.issue_src1 = 3; bus.issue_src_en = 3'b001;
    bus.issue_dst1 = 4; bus.issue_dst_en = 2'b01;
    #2 check("indep_accept", bus.exec_valid, 1);
    step();
    clear_all();

    // Same-edge set and clear of r9
    bus.issue_valid = 1; bus.issue_dst1 = 9; bus.issue_dst_en = 2'b01;
    bus.wb_wr2_enable = 1; bus.wb_wr2 = 9;
    step();
    idle();
    check("set_wins", bus.busy_any, 1);
    bus.issue_valid = 1; bus.issue_src2 = 9; bus.issue_src_en = 3'b010;
    step();
    clear_all();

    // Jump: two squashed cycles, then a re-jump in FLUSH extends to three
    bus.issue_valid = 1; bus.issue_src1 = 1; bus.issue_src_en = 3'b001;
    bus.jump_taken = 1;
    sq = 0;
    step(); sq += int'(last_squash);
    bus.jump_taken = 0;
    repeat (4) begin step(); sq += int'(last_squash); end
    check("flush_len", sq, FC);
    bus.jump_taken = 1;
    sq = 0;
    step(); sq += int'(last_squash);
    step(); sq += int'(last_squash);
    bus.jump_taken = 0;
    repeat (4) begin step(); sq += int'(last_squash); end
    check("flush_rejump_len", sq, FC + 1);

    // Stall counter saturation
    do_reset();
    bus.issue_valid = 1; bus.issue_dst1 = 12; bus.issue_dst_en = 2'b01;
    step();
    idle();
    bus.issue_valid = 1; bus.issue_src3 = 12; bus.issue_src_en = 3'b100;
    repeat (20) step();
    check("stall_sat", bus.stall_count, STALL_MAX);

    // Reset mid-FLUSH with r1, r2 busy
    do_reset();
    bus.issue_valid = 1; bus.issue_dst1 = 1; bus.issue_dst2 = 2; bus.issue_dst_en = 2'b11;
    step();
    idle();
    bus.issue_valid = 1; bus.issue_src1 = 1; bus.issue_src_en = 3'b001;
    step();
    bus.jump_taken = 1;
    step();
    bus.jump_taken = 0;
    reset = 1;
    bus.wb_wr1_enable = 1; bus.wb_wr1 = 3;
    step();
    reset = 0;
    idle();
    #2;
    check("rst_flush_squash", bus.squash, 0);
    check("rst_flush_busy",   bus.busy_any, 0);
    check("rst_flush_stall",  bus.stall_count, 0);
    step();

    // Random traffic on a small register window to provoke hazards
    for (int n = 0; n < 600; n++) begin
      bus.issue_valid   = ($urandom_range(0, 3) != 0);
      bus.issue_src1    = IW'($urandom_range(0, 7));
      bus.issue_src2    = IW'($urandom_range(0, 7));
      bus.issue_src3    = IW'($urandom_range(0, 7));
      bus.issue_src_en  = 3'($urandom_range(0, 7));
      bus.issue_dst1    = IW'($urandom_range(0, 7));
      bus.issue_dst2    = IW'($urandom_range(0, 7));
      bus.issue_dst_en  = 2'($urandom_range(0, 3));
      bus.wb_wr1_enable = ($urandom_range(0, 2) == 0);
      bus.wb_wr2_enable = ($urandom_range(0, 2) == 0);
      bus.wb_wr1        = IW'($urandom_range(0, 7));
      bus.wb_wr2        = IW'($urandom_range(0, 7));
      bus.jump_taken    = ($urandom_range(0, 15) == 0);
      reset             = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 0;
    idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
